// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//
// Issue-side sequencer for the 32-bit pipelined ALU. Tagged requests are
// buffered in a small FIFO and then sent to the ALU one at a time. The ALU
// picks its output combinationally from `opcode`, so this block holds
// alu_a/alu_b/alu_opcode steady for the whole latency of the selected unit.
// When that latency has elapsed, it captures alu_out and returns the result,
// together with its tag and opcode, on a valid/ready response port.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake (req_ready = FIFO not full)
//   req_opcode/a/b/tag    request payload
//   alu_a/alu_b/alu_opcode  registered operands and opcode to the ALU
//   alu_out               ALU result word
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/tag/opcode   captured result and its request attributes
//   busy                  FSM not idle or FIFO non-empty

module alu_issue_ctrl #(
    parameter int LAT_INT    = 4,
    parameter int LAT_FPADD  = 5,
    parameter int LAT_FPMUL  = 4,
    parameter int LAT_SHIFT  = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_opcode,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [31:0]      alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [2:0]       rsp_opcode,
    output logic             busy
);

    localparam int MAX_A   = (LAT_INT > LAT_FPADD) ? LAT_INT : LAT_FPADD;
    localparam int MAX_B   = (LAT_FPMUL > LAT_SHIFT) ? LAT_FPMUL : LAT_SHIFT;
    localparam int MAX_LAT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } req_t;

    // Unit latency minus one: the count loaded on the issue edge, so that
    // capture lands exactly L edges after issue.
    function automatic logic [CNT_W-1:0] lat_m1(input logic [2:0] op);
        int l;
        if (op[2])
            l = LAT_SHIFT;
        else if (!op[1])
            l = LAT_INT;
        else if (op[0])
            l = LAT_FPMUL;
        else
            l = LAT_FPADD;
        return CNT_W'(l - 1);
    endfunction

    // ---------------------------------------------------------------
    // Request FIFO (pointers carry one extra wrap bit for full/empty)
    // ---------------------------------------------------------------
    req_t             mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    req_t             head;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [TAG_W-1:0] tag_q;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign head      = mem[rd_ptr[PTR_W-1:0]];

    // Pop and issue are the same event: leaving IDLE, or a RESP handshake,
    // with work waiting.
    assign pop  = !empty && ((state == IDLE) || ((state == RESP) && rsp_ready));
    assign busy = (state != IDLE) || !empty;

    // NOTE: storage has no reset; the pointers alone define which entries
    // are valid, so clearing the array would only cost flops.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[PTR_W-1:0]] <= '{opcode: req_opcode, a: req_a, b: req_b, tag: req_tag};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Issue / execute / respond FSM
    // ---------------------------------------------------------------
    // NOTE: all state is assigned with <= so every register samples the
    // pre-edge values; the issue block below can therefore safely override
    // the state chosen in the case statement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            tag_q      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_tag    <= '0;
            rsp_opcode <= '0;
        end else begin
            case (state)
                IDLE: ;
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_data   <= alu_out;
                        rsp_tag    <= tag_q;
                        rsp_opcode <= alu_opcode;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Issue: ALU inputs change only here, so the ALU stays quiet
            // and its output mux sees a stable opcode in between.
            if (pop) begin
                alu_a      <= head.a;
                alu_b      <= head.b;
                alu_opcode <= head.opcode;
                tag_q      <= head.tag;
                cnt        <= lat_m1(head.opcode);
                state      <= EXEC;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: directed vectors, a behavioural pipelined
// ALU model, and a scoreboard queue drained by an independent monitor.

module tb_alu_issue_ctrl;

  localparam int TAG_W     = 4;
  localparam int L_INT     = 4;
  localparam int L_FPADD   = 5;
  localparam int L_FPMUL   = 4;
  localparam int L_SHIFT   = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_opcode = '0;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [2:0]       alu_opcode;
  logic [31:0]      alu_out;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic [2:0]       rsp_opcode;
  logic             busy;

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .LAT_INT(L_INT), .LAT_FPADD(L_FPADD), .LAT_FPMUL(L_FPMUL),
    .LAT_SHIFT(L_SHIFT), .FIFO_DEPTH(4), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_opcode(rsp_opcode), .busy(busy)
  );

  // ---------------- ALU model ----------------
  function automatic int lat(input logic [2:0] op);
    if (op[2]) return L_SHIFT;
    if (!op[1]) return L_INT;
    return op[0] ? L_FPMUL : L_FPADD;
  endfunction

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [5:0] s;
    s = {1'b0, b[4:0]};
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return (a == 32'h3F80_0000 && b == 32'h3F80_0000) ? 32'h4000_0000 : (a ^ b);
      3'd3: return (a == 32'h4000_0000 && b == 32'h4040_0000) ? 32'h40C0_0000 : ~(a ^ b);
      3'd4: return a >> s;
      3'd5: return (a >> s) | (a << (6'd32 - s));
      3'd6: return a << s;
      default: return (a << s) | (a >> (6'd32 - s));
    endcase
  endfunction

  // hist[k] holds the function of the ALU inputs as they were k+1 edges ago;
  // a unit of latency L presents its result L-1 edges after its inputs change.
  logic [31:0] hist [0:7];
  int          model_l;

  always @(posedge clk) begin
    hist[0] <= alu_f(alu_opcode, alu_a, alu_b);
    for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
  end

  always_comb begin
    model_l = lat(alu_opcode);
    if (model_l == 1) alu_out = alu_f(alu_opcode, alu_a, alu_b);
    else              alu_out = hist[model_l-2];
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic [2:0]       op;
  } rsp_t;

  rsp_t sb[$];
  rsp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a response is consumed on the edge after a negedge that sees
  // rsp_valid && rsp_ready; each such sample is one distinct response.
  initial forever begin
    @(negedge clk);
    if (reset && rsp_valid && rsp_ready) begin
      check("rsp_expected", (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("rsp_data_tag_op", {rsp_data, rsp_tag, rsp_opcode}, mon_e);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input logic [31:0] exp_data,
                      input int max_wait, output bit acc);
    acc        = 1'b0;
    req_valid  = 1'b1;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    req_tag    = tag;
    for (int w = 0; w < max_wait && !acc; w++) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1;
      tick();
      if (acc) sb.push_back({exp_data, tag, op});
    end
    req_valid = 1'b0;
  endtask

  // One request into an idle controller: inputs must be held from the issue
  // edge on, and rsp_valid must rise exactly L+1 edges after acceptance.
  task automatic run_single(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [TAG_W-1:0] tag,
                            input logic [31:0] exp_data, input int l);
    bit acc;
    rsp_ready = 1'b1;
    send(op, a, b, tag, exp_data, 4, acc);
    check({name, "_accept"}, acc, 1'b1);
    for (int k = 1; k <= l + 1; k++) begin
      tick();
      check({name, "_alu_hold"}, {alu_opcode, alu_a, alu_b}, {op, a, b});
      check({name, "_valid_timing"}, rsp_valid, (k == l + 1));
    end
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && (sb.size() != 0 || busy); i++) tick();
    check(name, {(sb.size() == 0), busy}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed tests ----------------
  initial begin
    bit acc;
    logic [31:0] ba [5];
    logic [31:0] bb [5];
    logic [2:0]  bo [5];
    logic [31:0] be [5];

    // Reset state
    #1;
    check("reset_state",
          {rsp_valid, rsp_data, rsp_tag, rsp_opcode, alu_a, alu_b, alu_opcode, busy, req_ready},
          {1'b0, 32'd0, 4'd0, 3'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b1});
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Int add 5+7, tag 3
    run_single("int_add", 3'b000, 32'd5, 32'd7, 4'd3, 32'd12, L_INT);
    tick();

    // Float add 1.0+1.0 exercises the longest unit
    run_single("fp_add", 3'b010, 32'h3F80_0000, 32'h3F80_0000, 4'd5, 32'h4000_0000, L_FPADD);
    tick();

    // Mixed latencies back-to-back
    rsp_ready = 1'b1;
    send(3'b011, 32'h4000_0000, 32'h4040_0000, 4'd1, 32'h40C0_0000, 4, acc);
    check("mix_accept0", acc, 1'b1);
    send(3'b110, 32'd1, 32'd4, 4'd2, 32'h10, 4, acc);
    check("mix_accept1", acc, 1'b1);
    wait_drain("mix_drain", 40);

    // Backpressure: 6 offered, 5 accepted, first response held
    rsp_ready = 1'b0;
    ba = '{32'd100, 32'd50, 32'h0000_00FF, 32'h8000_0001, 32'hF000_0000};
    bb = '{32'd23,  32'd60, 32'd8,         32'd4,         32'd28};
    bo = '{3'b000,  3'b001, 3'b110,        3'b111,        3'b100};
    be = '{32'd123, 32'hFFFF_FFF6, 32'h0000_FF00, 32'h0000_0018, 32'h0000_000F};
    for (int i = 0; i < 5; i++) begin
      send(bo[i], ba[i], bb[i], 4'(8 + i), be[i], 4, acc);
      check("bp_accept", acc, 1'b1);
    end
    check("bp_ready_low", req_ready, 1'b0);
    send(3'b000, 32'd1, 32'd1, 4'd13, 32'd2, 3, acc);
    check("bp_sixth_rejected", acc, 1'b0);
    for (int i = 0; i < 20 && !rsp_valid; i++) tick();
    check("bp_first_rsp", {rsp_valid, rsp_data, rsp_tag}, {1'b1, 32'd123, 4'd8});
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rsp_hold", {rsp_valid, rsp_data, rsp_tag, alu_a, busy, req_ready},
            {1'b1, 32'd123, 4'd8, 32'd100, 1'b1, 1'b0});
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_ready_after_pop", req_ready, 1'b1);
    wait_drain("bp_drain", 80);

    // Reset mid-EXEC with two entries queued
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(3'b010, 32'h3F80_0000, 32'h3F80_0000, 4'(i), 32'h4000_0000, 4, acc);
      check("rst_accept", acc, 1'b1);
    end
    check("rst_pre_exec", {busy, rsp_valid, alu_opcode}, {1'b1, 1'b0, 3'b010});
    #2;
    reset = 1'b0;
    #1;
    check("rst_async",
          {rsp_valid, busy, alu_a, alu_b, alu_opcode, req_ready},
          {1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1});
    sb.delete();
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("rst_no_stale", {rsp_valid, busy}, 2'b00);

    // Sub and rotate right after reset
    run_single("int_sub", 3'b001, 32'd10, 32'd3, 4'd6, 32'd7, L_INT);
    tick();
    run_single("rot_right", 3'b101, 32'h0000_0001, 32'd1, 4'd7, 32'h8000_0000, L_SHIFT);
    tick();
    wait_drain("final_drain", 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Request sequencer that drives the 32-bit pipelined ALU from the issuing side. It buffers tagged operation requests in a small FIFO and presents one operation at a time on the ALU's `a`/`b`/`opcode` inputs. Because the ALU selects its output combinationally from `opcode`, those inputs are held stable for the selected unit's pipeline latency. At the end of that latency the block captures the ALU `out` word and returns it with its tag on a valid/ready response port.

## Interface

Parameters:
- `LAT_INT`, default 4: pipeline latency in clock edges of integer add/sub (opcodes 000/001); must be ≥1.
- `LAT_FPADD`, default 5: latency of float add (010); ≥1.
- `LAT_FPMUL`, default 4: latency of float multiply (011); ≥1.
- `LAT_SHIFT`, default 3: latency of shift/rotate (1xx); ≥1.
- `FIFO_DEPTH`, default 4: request FIFO entries; power of two, ≥2.
- `TAG_W`, default 4: request tag width.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: FIFO not full.
- `req_opcode` input 3: ALU opcode.
- `req_a`, `req_b` input 32: operands.
- `req_tag` input TAG_W: caller tag.
- `alu_a`, `alu_b` output 32: registered operands to ALU `a`/`b`.
- `alu_opcode` output 3: registered opcode to ALU `opcode`.
- `alu_out` input 32: ALU `out`.
- `rsp_valid` output 1: result held.
- `rsp_ready` input 1: consumer accepts.
- `rsp_data` output 32: captured result.
- `rsp_tag` output TAG_W: tag of the result.
- `rsp_opcode` output 3: opcode of the result.
- `busy` output 1: state ≠ IDLE or FIFO non-empty.

## Operation

- Opcode map: 000 int add, 001 int sub, 010 fp add, 011 fp mul, 100 shift right, 101 rotate right, 110 shift left, 111 rotate left.
- Latency select L(op): `op[2]=1` → LAT_SHIFT; 000/001 → LAT_INT; 010 → LAT_FPADD; 011 → LAT_FPMUL.
- FIFO: a push happens on an edge with `req_valid && req_ready`. `req_ready = !full`. When full, `req_ready` stays low even if a pop occurs on the same edge. There is no bypass: an entry is visible to the FSM on the edge after its push.
- FSM states:
  - IDLE:
    - FIFO non-empty → pop the entry; load `alu_a`/`alu_b`/`alu_opcode`, the tag register and `cnt <= L(op)-1`; go to EXEC.
    - FIFO empty → stay in IDLE.
  - EXEC:
    - `cnt != 0` → `cnt <= cnt-1`.
    - `cnt == 0` → `rsp_data <= alu_out`, `rsp_tag`/`rsp_opcode` loaded; go to RESP.
  - RESP: `rsp_valid = 1`; outputs held while `rsp_ready = 0`. On an edge with `rsp_ready = 1`:
    - FIFO non-empty → perform the IDLE issue actions; go to EXEC.
    - FIFO empty → go to IDLE.
- `alu_a`/`alu_b`/`alu_opcode` change only on issue edges and hold their last values in IDLE/RESP. This keeps the ALU quiet and keeps the opcode stable for the output mux.
- Responses return strictly in request order.
- `cnt` width is `$clog2(max latency)+1`.

## Timing

- Reset (`reset` low, asynchronous):
  - State IDLE; FIFO empty.
  - `rsp_valid=0`, `rsp_data=0`, `rsp_tag=0`, `rsp_opcode=0`.
  - `alu_a=0`, `alu_b=0`, `alu_opcode=0`, `busy=0`.
  - `req_ready=1`; pushes are ignored while reset is low.
- Reset mid-operation discards the in-flight op and all FIFO contents, and drops `rsp_valid` immediately.
- Issue edge E0 → capture edge E0+L, so the operands are held for exactly L cycles.
- Accept edge Ea with an idle FSM → issue at Ea+1 → `rsp_valid` high after edge Ea+1+L, i.e. L+1 cycles of latency.
- Throughput with `rsp_ready` held high: one op per L+1 cycles (EXEC for L edges, RESP for 1 edge).
- Maximum outstanding requests: FIFO_DEPTH in the FIFO plus 1 in EXEC/RESP.

## Test plan

- Int add, defaults: `req_a=5`, `req_b=7`, op 000, tag 3 accepted at edge 0 → `rsp_valid` high after edge 5, `rsp_data=12`, `rsp_tag=3`, `rsp_opcode=000`; `alu_opcode` stable at 000 across edges 1–5.
- Mixed latencies: fp mul (2.0×3.0, 0x40000000/0x40400000, tag 1), then shift left (a=1, b=4, tag 2), back-to-back with `rsp_ready=1` → first response 0x40C00000 tag 1, then 0x10 tag 2, in order.
- Backpressure: hold `rsp_ready=0` and push 6 requests → 5 accepted, `req_ready` low from the edge after the 5th accept. The first response stays stable. Release `rsp_ready` → all 5 responses drain in order, and `req_ready` rises after the first pop.
- Response hold: with `rsp_valid=1` and `rsp_ready=0` for 10 cycles → `rsp_data`/`rsp_tag` unchanged, no new issue, `busy=1`.
- Reset mid-EXEC with 2 entries queued: assert `reset` low → `rsp_valid`, `busy`, `alu_*` go to 0 asynchronously. After release, no stale response appears; a new request then completes normally.
- Sub, rotate right: 10−3 → 7 (op 001); rotate right of 0x00000001 by 1 → 0x80000000 (op 101); each observed after L+1 cycles.
